accel_sample_filter: RTL and testbench
======================================

# accel_sample_filter

Moving-average and tilt-detect stage that sits directly downstream of the accelerometer SPI driver. It consumes one signed 8-bit axis sample per valid strobe and keeps a circular window of the last 2^LOG2_DEPTH samples. It produces a registered windowed average with a one-cycle valid pulse, plus a threshold-based tilt flag that the attitude/motor logic reads.

## Interface
- LOG2_DEPTH, 3, log2 of window depth (DEPTH = 8 by default); legal range 1..5
- THRESH, 64, unsigned tilt threshold on |average|, range 0..128
- CLK12M  input  1  system clock; all logic on rising edge
- RST_N  input  1  reset; asynchronous and active-low
- in_data  input  8  two's-complement sample from the SPI driver
- in_valid  input  1  sample strobe; one sample accepted per cycle it is high
- clear  input  1  synchronous flush of window and state
- avg  output  8  two's-complement windowed average
- avg_valid  output  1  one-cycle pulse, avg/tilt updated this cycle
- tilt  output  1  high when |avg| >= THRESH
- filled  output  1  high once the window holds DEPTH samples

## Operation
- FSM states:
  - FILL (reset state): window not yet full.
  - RUN: window full.
- Storage:
  - Window buffer: DEPTH x 8 bits.
  - wr_ptr: LOG2_DEPTH bits, wraps DEPTH-1 -> 0.
  - fill_cnt: LOG2_DEPTH+1 bits.
  - sum: signed, 8+LOG2_DEPTH bits. Never overflows: DEPTH x (-128..127) always fits.
- On an accepted sample (in_valid=1, clear=0):
  - buf[wr_ptr] <= in_data.
  - wr_ptr++.
  - sum <= sum + in_data - oldest.
  - oldest = buf[wr_ptr] in RUN, 0 in FILL. The buffer itself is not reset.
- FILL:
  - fill_cnt++ on each accepted sample.
  - When fill_cnt becomes DEPTH, go to RUN; filled <= 1 on that same edge.
- RUN:
  - Stays in RUN until clear or reset.
  - fill_cnt holds at DEPTH.
- Output stage, one registered stage after the sum update:
  - avg = sum >>> LOG2_DEPTH, arithmetic shift, i.e. floor toward -inf, truncated to 8 bits (always in range).
  - tilt = (|avg| >= THRESH), with |avg| computed in 9 bits so that -128 gives 128.
  - avg_valid = 1 only for samples accepted while in RUN, or for the sample that completes the fill.
  - No avg_valid for earlier FILL samples; avg and tilt hold their values there.
- clear:
  - Highest priority over in_valid; a sample presented in the same cycle is dropped.
  - Sets state to FILL and zeroes sum, wr_ptr, fill_cnt and filled.
  - Sets avg=0, tilt=0, avg_valid=0 on the next edge.
  - Suppresses the avg_valid pulse of any sample still in the output stage.
- Back-to-back in_valid (every cycle) is supported at full throughput; no backpressure exists.

## Timing
- Reset (RST_N=0, asynchronous) values:
  - avg=0, avg_valid=0, tilt=0, filled=0.
  - State FILL; sum, wr_ptr and fill_cnt all 0.
- Reset asserted mid-operation discards the window immediately, including any pending output.
- Sample accepted at edge k:
  - sum updated at edge k.
  - avg, tilt and avg_valid updated at edge k+1.
  - Latency is 2 edges, input to output.
- avg_valid is high for exactly one cycle per qualifying sample. With continuous in_valid in RUN it stays high continuously.
- filled rises at the edge that accepts the DEPTH-th sample, one cycle before the first avg_valid.
- clear at edge k:
  - avg_valid=0 from edge k+1 onward.
  - The next DEPTH accepted samples restart the fill.

## Test plan
- Reset, then 8 samples of 10 on consecutive cycles:
  - filled rises with the 8th sample.
  - One cycle later, avg_valid=1 with avg=10 and tilt=0.
  - No avg_valid for samples 1-7.
- Window full of 10, then one sample of 18: sum 88, avg=11, avg_valid for one cycle.
- Negative floor:
  - 8 samples of -3 give avg=-3.
  - Then sample 0 gives sum=-21 and avg=-3 (floor of -2.625).
- Tilt boundaries with THRESH=64:
  - 8 x 64 gives tilt=1.
  - 8 x -64 gives tilt=1.
  - 8 x 63 gives tilt=0.
  - 8 x -128 gives avg=-128, tilt=1, sum=-1024 with no overflow.
  - 8 x 127 gives avg=127.
- clear behaviour:
  - 5 samples, then clear asserted together with in_valid: that sample is dropped and filled=0.
  - 7 more samples produce no avg_valid.
  - The 8th sample produces avg_valid with the average of post-clear samples only.
- Reset mid-RUN:
  - Drop RST_N asynchronously between edges: all outputs are 0 immediately.
  - After release, 8 samples are required before the next avg_valid.
  - A sample with in_valid high in the cycle RST_N releases is accepted normally.

Source files
------------

// File: rtl/accel_sample_filter_if.sv
// Sample-filter bus: raw accelerometer samples in, windowed average and tilt flag out.
//   in_data   : signed 8-bit sample from the SPI driver
//   in_valid  : sample strobe
//   clear     : synchronous flush of the filter
//   avg       : signed 8-bit windowed average
//   avg_valid : one-cycle pulse when avg/tilt were updated
//   tilt      : |avg| >= threshold
//   filled    : window holds a full set of samples
// master drives the sample side, slave is the filter.
interface accel_sample_filter_if;
    logic [7:0] in_data;
    logic       in_valid;
    logic       clear;
    logic [7:0] avg;
    logic       avg_valid;
    logic       tilt;
    logic       filled;

    modport master (
        output in_data, in_valid, clear,
        input  avg, avg_valid, tilt, filled
    );

    modport slave (
        input  in_data, in_valid, clear,
        output avg, avg_valid, tilt, filled
    );
endinterface

// File: rtl/accel_sample_filter.sv
// Moving-average and tilt-detect stage for one accelerometer axis.
// Keeps the last 2^LOG2_DEPTH samples in a circular window, maintains a running
// sum, and presents a registered floor-average plus tilt flag one edge after
// each qualifying sample.
//   CLK12M : system clock, rising edge
//   RST_N  : asynchronous active-low reset
//   sf     : filter bus (slave side), see accel_sample_filter_if
module accel_sample_filter #(
    parameter int unsigned LOG2_DEPTH = 3,
    parameter int unsigned THRESH     = 64
) (
    input  logic                  CLK12M,
    input  logic                  RST_N,
    accel_sample_filter_if.slave  sf
);
    localparam int unsigned DEPTH = 1 << LOG2_DEPTH;
    localparam int unsigned SW    = 8 + LOG2_DEPTH;
    localparam int unsigned CW    = LOG2_DEPTH + 1;

    typedef enum logic {FILL, RUN} state_t;

    state_t                 state, state_nxt;
    logic [7:0]             win [DEPTH];
    logic [LOG2_DEPTH-1:0]  wr_ptr, wr_ptr_nxt;
    logic [CW-1:0]          fill_cnt, fill_cnt_nxt;
    logic signed [SW-1:0]   sum, sum_nxt;
    logic                   filled_r, filled_nxt;
    logic                   pend, pend_nxt;
    logic [7:0]             avg_r, avg_nxt;
    logic                   tilt_r, tilt_nxt;
    logic                   avg_valid_r, avg_valid_nxt;

    logic                   accept_c;
    logic [7:0]             oldest_c;
    logic [7:0]             avg_c;
    logic [8:0]             avg_ext_c;
    logic [8:0]             mag_c;

    assign accept_c  = sf.in_valid & ~sf.clear;
    // Before the window is full the slot being overwritten holds stale data.
    assign oldest_c  = (state == RUN) ? win[wr_ptr] : 8'd0;
    assign avg_c     = 8'(sum >>> LOG2_DEPTH);
    // 9-bit magnitude so that -128 maps to 128.
    assign avg_ext_c = 9'($signed(avg_c));
    assign mag_c     = avg_ext_c[8] ? (~avg_ext_c + 9'd1) : avg_ext_c;

    // Next-state, datapath and output-stage logic.
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        fill_cnt_nxt  = fill_cnt;
        sum_nxt       = sum;
        filled_nxt    = filled_r;
        pend_nxt      = 1'b0;
        avg_nxt       = avg_r;
        tilt_nxt      = tilt_r;
        avg_valid_nxt = 1'b0;

        // pend marks that sum was updated by a qualifying sample last edge.
        if (pend) begin
            avg_nxt       = avg_c;
            tilt_nxt      = (mag_c >= 9'(THRESH));
            avg_valid_nxt = 1'b1;
        end

        if (sf.clear) begin
            state_nxt     = FILL;
            wr_ptr_nxt    = '0;
            fill_cnt_nxt  = '0;
            sum_nxt       = '0;
            filled_nxt    = 1'b0;
            avg_nxt       = 8'd0;
            tilt_nxt      = 1'b0;
            avg_valid_nxt = 1'b0;
        end else if (accept_c) begin
            wr_ptr_nxt = wr_ptr + LOG2_DEPTH'(1);
            sum_nxt    = sum + SW'($signed(sf.in_data)) - SW'($signed(oldest_c));
            case (state)
                FILL: begin
                    fill_cnt_nxt = fill_cnt + CW'(1);
                    if (fill_cnt == CW'(DEPTH - 1)) begin
                        state_nxt  = RUN;
                        filled_nxt = 1'b1;
                        pend_nxt   = 1'b1;
                    end
                end
                RUN: pend_nxt = 1'b1;
                default: state_nxt = FILL;
            endcase
        end
    end

    // State and control registers.
    always_ff @(posedge CLK12M or negedge RST_N) begin
        if (!RST_N) begin
            state       <= FILL;
            wr_ptr      <= '0;
            fill_cnt    <= '0;
            sum         <= '0;
            filled_r    <= 1'b0;
            pend        <= 1'b0;
            avg_r       <= 8'd0;
            tilt_r      <= 1'b0;
            avg_valid_r <= 1'b0;
        end else begin
            state       <= state_nxt;
            wr_ptr      <= wr_ptr_nxt;
            fill_cnt    <= fill_cnt_nxt;
            sum         <= sum_nxt;
            filled_r    <= filled_nxt;
            pend        <= pend_nxt;
            avg_r       <= avg_nxt;
            tilt_r      <= tilt_nxt;
            avg_valid_r <= avg_valid_nxt;
        end
    end

    // Window storage; contents are masked by FILL state so no reset is needed.
    always_ff @(posedge CLK12M) begin
        if (accept_c) begin
            win[wr_ptr] <= sf.in_data;
        end
    end

    assign sf.avg       = avg_r;
    assign sf.tilt      = tilt_r;
    assign sf.avg_valid = avg_valid_r;
    assign sf.filled    = filled_r;
endmodule

// File: tb/tb_accel_sample_filter.sv
// Self-checking bench for accel_sample_filter with a scoreboard of expected
// averages built from a reference window model.
module tb_accel_sample_filter;
    localparam int DEPTH  = 8;
    localparam int THRESH = 64;

    logic CLK12M;
    logic RST_N;

    accel_sample_filter_if sf ();

    accel_sample_filter #(
        .LOG2_DEPTH (3),
        .THRESH     (THRESH)
    ) dut (
        .CLK12M (CLK12M),
        .RST_N  (RST_N),
        .sf     (sf.slave)
    );

    int checks = 0;
    int errors = 0;
    int win[$];
    int exp_avg[$];
    int exp_tilt[$];
    int mon_avg;
    int mon_tilt;

    initial CLK12M = 1'b0;
    always #5 CLK12M = ~CLK12M;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int floor_avg(input int s);
        if (s >= 0) return s / DEPTH;
        return -((-s + DEPTH - 1) / DEPTH);
    endfunction

    task automatic model_flush();
        win.delete();
        exp_avg.delete();
        exp_tilt.delete();
    endtask

    task automatic model_accept(input int d);
        int s;
        int a;
        win.push_back(d);
        if (win.size() > DEPTH) void'(win.pop_front());
        if (win.size() == DEPTH) begin
            s = 0;
            foreach (win[i]) s += win[i];
            a = floor_avg(s);
            exp_avg.push_back(a);
            exp_tilt.push_back(((a < 0) ? -a : a) >= THRESH);
        end
    endtask

    // Drive one cycle of stimulus at the falling edge, check filled after the edge.
    task automatic send(input int d, input bit v, input bit c);
        @(negedge CLK12M);
        sf.in_data  = 8'(d);
        sf.in_valid = v;
        sf.clear    = c;
        if (c) model_flush();
        else if (v) model_accept(d);
        @(posedge CLK12M);
        #1;
        check("filled", int'(sf.filled), int'(win.size() == DEPTH));
        if (c) begin
            check("clear_avg", int'($signed(sf.avg)), 0);
            check("clear_tilt", int'(sf.tilt), 0);
            check("clear_valid", int'(sf.avg_valid), 0);
        end
    endtask

    task automatic burst(input int d, input int n);
        for (int i = 0; i < n; i++) send(d, 1'b1, 1'b0);
    endtask

    // Scoreboard: every avg_valid pulse must match the oldest expected result.
    always @(posedge CLK12M) begin
        #1;
        if (RST_N && sf.avg_valid) begin
            if (exp_avg.size() == 0) begin
                check("spurious_valid", int'(sf.avg_valid), 0);
            end else begin
                mon_avg  = exp_avg.pop_front();
                mon_tilt = exp_tilt.pop_front();
                check("avg", int'($signed(sf.avg)), mon_avg);
                check("tilt", int'(sf.tilt), mon_tilt);
            end
        end
    end

    initial begin
        RST_N       = 1'b0;
        sf.in_data  = 8'd0;
        sf.in_valid = 1'b0;
        sf.clear    = 1'b0;
        repeat (3) @(posedge CLK12M);
        #1;
        check("rst_avg", int'($signed(sf.avg)), 0);
        check("rst_valid", int'(sf.avg_valid), 0);
        check("rst_tilt", int'(sf.tilt), 0);
        check("rst_filled", int'(sf.filled), 0);
        @(negedge CLK12M);
        RST_N = 1'b1;

        // Fill with 10s, then slide in an 18.
        burst(10, 8);
        send(18, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);

        // Negative values and floor rounding.
        send(0, 1'b0, 1'b1);
        burst(-3, 8);
        send(0, 1'b1, 1'b0);
        send(0, 1'b0, 1'b0);

        // Tilt boundaries and extremes, back to back.
        send(0, 1'b0, 1'b1);
        burst(64, 8);
        burst(-64, 8);
        burst(63, 8);
        burst(-63, 8);
        burst(-128, 8);
        burst(127, 8);
        for (int i = 0; i < 12; i++) send(int'($urandom_range(255)) - 128, 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) send(int'($urandom_range(255)) - 128, ($urandom_range(1) == 1), 1'b0);
        send(0, 1'b0, 1'b0);

        // Clear with a coincident sample, then refill from scratch.
        send(0, 1'b0, 1'b1);
        burst(100, 5);
        send(100, 1'b1, 1'b1);
        burst(20, 7);
        send(-40, 1'b1, 1'b0);
        burst(5, 3);

        // Clear while a result is still in the output stage.
        send(0, 1'b0, 1'b1);
        burst(30, 8);
        send(0, 1'b1, 1'b1);
        send(0, 1'b0, 1'b0);

        // Asynchronous reset mid-RUN.
        burst(50, 10);
        @(negedge CLK12M);
        sf.in_valid = 1'b0;
        #2;
        RST_N = 1'b0;
        #1;
        model_flush();
        check("arst_avg", int'($signed(sf.avg)), 0);
        check("arst_valid", int'(sf.avg_valid), 0);
        check("arst_tilt", int'(sf.tilt), 0);
        check("arst_filled", int'(sf.filled), 0);
        @(negedge CLK12M);
        RST_N       = 1'b1;
        sf.in_data  = 8'(-100);
        sf.in_valid = 1'b1;
        model_accept(-100);
        @(posedge CLK12M);
        #1;
        check("filled", int'(sf.filled), int'(win.size() == DEPTH));
        burst(-100, 7);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);
        send(0, 1'b0, 1'b0);

        check("sb_empty", exp_avg.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
